sw_hex_counter: RTL and testbench



---
 rtl/sw_hex_counter_if.sv | 25 ++
 rtl/sw_hex_counter.sv | 174 +++++++++++++++++
 tb/tb_sw_hex_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sw_hex_counter_if.sv
// Control, switch and display signals of one sw_hex_counter instance.
// Board-side logic drives through master; the counter is the slave.
interface sw_hex_counter_if #(
  parameter int N_DIGITS = 6
);
  logic                  enable;
  logic                  up;
  logic                  dec_mode;
  logic                  load;
  logic [4*N_DIGITS-1:0] load_value;
  logic                  blank_lz;
  logic [4*N_DIGITS-1:0] count;
  logic                  wrap;
  logic [7*N_DIGITS-1:0] HEX;

  modport master (
    output enable, up, dec_mode, load, load_value, blank_lz,
    input  count, wrap, HEX
  );

  modport slave (
    input  enable, up, dec_mode, load, load_value, blank_lz,
    output count, wrap, HEX
  );
endinterface

// File: rtl/sw_hex_counter.sv
// Prescaled N-digit hex/BCD up/down counter with parallel load driving active-low HEX displays.
// count/wrap update at the tick/load edge, HEX one cycle later; no backpressure, enable only pauses.
module sw_hex_counter #(
  parameter int N_DIGITS = 6,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 10
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  sw_hex_counter_if.slave  bus
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW       = 4 * N_DIGITS;
  localparam int HW       = 7 * N_DIGITS;

  if (N_DIGITS < 1 || N_DIGITS > 6) begin : g_bad_digits
    $error("sw_hex_counter: N_DIGITS must be 1..6");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("sw_hex_counter: CLK_HZ/TICK_HZ must be >= 1");
  end

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;
  localparam logic [6:0]    SEG_ZERO   = 7'h40;

  logic [PW-1:0] presc_q, presc_d;
  logic          load_q;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [HW-1:0] hex_q, hex_d;

  logic          tick;
  logic          load_pulse;
  logic [CW-1:0] count_clean;
  logic [CW:0]   stepped;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = clamp9(v[4*i +: 4]);
    end
    return r;
  endfunction

  // Ripple carry/borrow across digits; the MSB of the result is the wrap flag.
  function automatic logic [CW:0] step(input logic [CW-1:0] v,
                                       input logic up_dir,
                                       input logic dec);
    logic [CW-1:0] r;
    logic [3:0]    dmax;
    logic [3:0]    d;
    logic          c;
    r    = v;
    dmax = dec ? 4'd9 : 4'hF;
    c    = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up_dir) begin
          if (d == dmax) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = dmax;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan from the top digit; blank until the first nonzero, never blank digit 0.
  function automatic logic [HW-1:0] render(input logic [CW-1:0] v, input logic blank);
    logic [HW-1:0] r;
    logic          seen;
    r    = '0;
    seen = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'd0) seen = 1'b1;
      if (blank && !seen && i != 0) begin
        r[7*i +: 7] = SEG_BLANK;
      end else begin
        r[7*i +: 7] = seg7(v[4*i +: 4]);
      end
    end
    return r;
  endfunction

  assign tick       = bus.enable && (presc_q == PRESC_LAST);
  assign load_pulse = bus.load && !load_q;

  assign count_clean = bus.dec_mode ? sanitise(count_q) : count_q;
  assign stepped     = step(count_clean, bus.up, bus.dec_mode);

  always_comb begin
    presc_d = presc_q;
    count_d = count_clean;
    wrap_d  = 1'b0;
    if (load_pulse) begin
      presc_d = '0;
      count_d = bus.dec_mode ? sanitise(bus.load_value) : bus.load_value;
    end else begin
      if (bus.enable) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        count_d = stepped[CW-1:0];
        wrap_d  = stepped[CW];
      end
    end
  end

  assign hex_d = render(count_q, bus.blank_lz);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      load_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= {N_DIGITS{SEG_ZERO}};
    end else begin
      presc_q <= presc_d;
      load_q  <= bus.load;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.HEX   = hex_q;

endmodule

// File: tb/tb_sw_hex_counter.sv
// Directed bench: a 2-digit counter (prescale 4) for counting/wrap/load/hold/reset
// and an idle 4-digit counter for segment decode and leading-zero blanking.
module tb_sw_hex_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sw_hex_counter_if #(.N_DIGITS(2)) a_if ();
  sw_hex_counter_if #(.N_DIGITS(4)) b_if ();

  sw_hex_counter #(.N_DIGITS(2), .CLK_HZ(4), .TICK_HZ(1)) dut_a (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (a_if.slave)
  );

  sw_hex_counter #(.N_DIGITS(4), .CLK_HZ(4), .TICK_HZ(1)) dut_b (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [15:0] v);
    b_if.load_value = v;
    b_if.load = 1'b1;
    cyc(1);
    b_if.load = 1'b0;
    cyc(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    a_if.enable = 1'b0; a_if.up = 1'b1; a_if.dec_mode = 1'b0;
    a_if.load = 1'b0; a_if.load_value = '0; a_if.blank_lz = 1'b0;
    b_if.enable = 1'b0; b_if.up = 1'b1; b_if.dec_mode = 1'b0;
    b_if.load = 1'b0; b_if.load_value = '0; b_if.blank_lz = 1'b0;
    cyc(2);
    chk("rst_count", 64'(a_if.count), 64'h00);
    chk("rst_wrap", 64'(a_if.wrap), 64'h0);
    chk("rst_hex", 64'(a_if.HEX), {50'h0, 7'h40, 7'h40});
    chk("rst_hex_b", 64'(b_if.HEX), {36'h0, 7'h40, 7'h40, 7'h40, 7'h40});

    // Free-running count, prescale 4
    reset = 1'b0;
    a_if.enable = 1'b1;
    cyc(3);
    chk("cnt_pre_tick", 64'(a_if.count), 64'h00);
    cyc(1);
    chk("cnt_tick1", 64'(a_if.count), 64'h01);
    chk("hex_lag", 64'(a_if.HEX), {50'h0, 7'h40, 7'h40});
    cyc(1);
    chk("hex_tick1", 64'(a_if.HEX), {50'h0, 7'h40, 7'h79});
    cyc(3);
    chk("cnt_tick2", 64'(a_if.count), 64'h02);

    // Hex wrap up and down
    a_if.load_value = 8'hFE;
    a_if.load = 1'b1;
    cyc(1);
    chk("hex_load", 64'(a_if.count), 64'hFE);
    a_if.load = 1'b0;
    cyc(4);
    chk("hex_ff", 64'(a_if.count), 64'hFF);
    chk("hex_ff_wrap", 64'(a_if.wrap), 64'h0);
    cyc(4);
    chk("hex_wrap_cnt", 64'(a_if.count), 64'h00);
    chk("hex_wrap", 64'(a_if.wrap), 64'h1);
    cyc(1);
    chk("hex_wrap_pulse", 64'(a_if.wrap), 64'h0);
    a_if.up = 1'b0;
    cyc(3);
    chk("hex_down_cnt", 64'(a_if.count), 64'hFF);
    chk("hex_down_wrap", 64'(a_if.wrap), 64'h1);

    // Decimal mode
    a_if.dec_mode = 1'b1;
    a_if.up = 1'b1;
    a_if.load_value = 8'h98;
    a_if.load = 1'b1;
    cyc(1);
    chk("dec_load", 64'(a_if.count), 64'h98);
    a_if.load = 1'b0;
    cyc(4);
    chk("dec_99", 64'(a_if.count), 64'h99);
    chk("dec_99_wrap", 64'(a_if.wrap), 64'h0);
    cyc(4);
    chk("dec_wrap_cnt", 64'(a_if.count), 64'h00);
    chk("dec_wrap", 64'(a_if.wrap), 64'h1);
    a_if.up = 1'b0;
    cyc(4);
    chk("dec_down_cnt", 64'(a_if.count), 64'h99);
    chk("dec_down_wrap", 64'(a_if.wrap), 64'h1);
    cyc(1);
    chk("dec_hex99", 64'(a_if.HEX), {50'h0, 7'h10, 7'h10});
    a_if.load_value = 8'hAB;
    a_if.load = 1'b1;
    cyc(1);
    chk("dec_clamp", 64'(a_if.count), 64'h99);
    a_if.load = 1'b0;
    a_if.dec_mode = 1'b0;
    cyc(1);
    a_if.load = 1'b1;
    cyc(1);
    chk("hex_load_ab", 64'(a_if.count), 64'hAB);
    a_if.load = 1'b0;
    a_if.dec_mode = 1'b1;
    cyc(1);
    chk("sanitise", 64'(a_if.count), 64'h99);

    // Load coinciding with a tick
    a_if.dec_mode = 1'b0;
    a_if.up = 1'b1;
    a_if.load_value = 8'h05;
    a_if.load = 1'b1;
    cyc(1);
    a_if.load = 1'b0;
    cyc(3);
    chk("coll_pre", 64'(a_if.count), 64'h05);
    a_if.load_value = 8'h30;
    a_if.load = 1'b1;
    cyc(1);
    chk("coll_cnt", 64'(a_if.count), 64'h30);
    chk("coll_wrap", 64'(a_if.wrap), 64'h0);
    a_if.load = 1'b0;
    cyc(3);
    chk("coll_hold", 64'(a_if.count), 64'h30);
    chk("coll_hex", 64'(a_if.HEX), {50'h0, 7'h30, 7'h40});
    cyc(1);
    chk("coll_next", 64'(a_if.count), 64'h31);

    // Enable low freezes count and prescaler phase
    cyc(2);
    a_if.enable = 1'b0;
    cyc(10);
    chk("hold_cnt", 64'(a_if.count), 64'h31);
    a_if.enable = 1'b1;
    cyc(1);
    chk("hold_phase", 64'(a_if.count), 64'h31);
    cyc(1);
    chk("hold_resume", 64'(a_if.count), 64'h32);

    // Four-digit decode and leading-zero blanking
    b_if.blank_lz = 1'b1;
    load_b(16'h0070);
    chk("b_cnt_0070", 64'(b_if.count), 64'h0070);
    chk("b_blank_0070", 64'(b_if.HEX), {36'h0, 7'h7F, 7'h7F, 7'h78, 7'h40});
    load_b(16'h0000);
    chk("b_blank_0", 64'(b_if.HEX), {36'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    b_if.blank_lz = 1'b0;
    cyc(1);
    chk("b_noblank_0", 64'(b_if.HEX), {36'h0, 7'h40, 7'h40, 7'h40, 7'h40});
    b_if.blank_lz = 1'b1;
    load_b(16'h1000);
    chk("b_blank_1000", 64'(b_if.HEX), {36'h0, 7'h79, 7'h40, 7'h40, 7'h40});
    load_b(16'hABCD);
    chk("b_seg_abcd", 64'(b_if.HEX), {36'h0, 7'h08, 7'h03, 7'h46, 7'h21});
    load_b(16'h0EF5);
    chk("b_seg_0ef5", 64'(b_if.HEX), {36'h0, 7'h7F, 7'h06, 7'h0E, 7'h12});

    // Reset mid-count
    reset = 1'b1;
    cyc(1);
    chk("midrst_cnt", 64'(a_if.count), 64'h00);
    chk("midrst_wrap", 64'(a_if.wrap), 64'h0);
    chk("midrst_hex", 64'(a_if.HEX), {50'h0, 7'h40, 7'h40});
    chk("midrst_hex_b", 64'(b_if.HEX), {36'h0, 7'h40, 7'h40, 7'h40, 7'h40});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
